// File: rtl/disp7seg_scan_n.sv
// Multiplexed common-anode 7-segment scanner with prescaler,
// PWM brightness, leading-zero blanking, per-digit blink and dead-time.
module disp7seg_scan_n #(
    parameter int NDIG         = 4,
    parameter int PRESCALE     = 1000,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clockscan,
    input  logic                  areset_n,
    input  logic                  clkenable,
    input  logic [4*NDIG-1:0]     digits,
    input  logic [NDIG-1:0]       dps,
    input  logic                  blank_lz,
    input  logic [NDIG-1:0]       blink_mask,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NDIG-1:0]       en_n,
    output logic                  frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(NDIG);
    localparam int OW = PW + BRIGHT_W + 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);
    localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       fcnt;
    logic                blink_phase;
    logic [BRIGHT_W-1:0] br;

    logic                slot_end;
    logic                frame_end;
    logic [OW-1:0]       on_prod;
    logic [OW-1:0]       on_cyc;
    logic [NDIG-1:0]     blank;
    logic                zero_above;
    logic [3:0]          cur;
    logic                lit;
    logic [NDIG-1:0]     en_d;
    logic [6:0]          seg_d;
    logic                dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h0D;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            4'hF: s = 7'h47;
        endcase
        return s;
    endfunction

    assign slot_end  = clkenable && (pcnt == PLAST);
    assign frame_end = slot_end && (idx == '0);

    // On-time threshold scales the slot length by (br+1)/2**BRIGHT_W
    assign on_prod = (OW'(br) + OW'(1)) * OW'(PRESCALE);
    assign on_cyc  = on_prod >> BRIGHT_W;

    // Per-digit blanking: blink phase, or all digits from here upward are zero
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_above = zero_above && (digits[4*i +: 4] == 4'h0);
            blank[i]   = (blink_mask[i] && blink_phase)
                       || (blank_lz && zero_above && (i != 0));
        end
    end

    assign cur = digits[{idx, 2'b00} +: 4];
    assign lit = (pcnt != '0) && (OW'(pcnt) < on_cyc) && !blank[idx];

    // Next-state of the pin drivers; dark whenever the digit is not lit
    always_comb begin
        en_d = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (lit && (idx == IW'(i))) begin
                en_d[i] = 1'b0;
            end
        end
        seg_d = lit ? ~hex7(cur) : 7'h7F;
        dp_d  = lit ? ~dps[idx] : 1'b1;
    end

    // Scan prescaler, digit index, frame counter, blink phase, brightness latch
    always_ff @(posedge clockscan or negedge areset_n) begin
        if (!areset_n) begin
            pcnt        <= '0;
            idx         <= ILAST;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            br          <= '0;
        end else begin
            if (pcnt == '0) begin
                br <= brightness;
            end
            if (clkenable) begin
                pcnt <= slot_end ? '0 : pcnt + PW'(1);
            end
            if (slot_end) begin
                idx <= (idx == '0) ? ILAST : idx - IW'(1);
            end
            if (frame_end) begin
                if (fcnt == FLAST) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    // Registered pin drivers and frame pulse
    always_ff @(posedge clockscan or negedge areset_n) begin
        if (!areset_n) begin
            en_n       <= '1;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            en_n       <= en_d;
            seg_n      <= seg_d;
            dp_n       <= dp_d;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_disp7seg_scan_n.sv
// Scoreboard bench for disp7seg_scan_n: stimulus queues timestamped
// expectations, a negedge monitor pops and compares them.
module tb_disp7seg_scan_n;

    localparam int NDIG = 4;

    logic        clockscan = 1'b0;
    logic        areset_n  = 1'b1;
    logic        clkenable = 1'b1;
    logic [15:0] digits    = 16'h0000;
    logic [3:0]  dps       = 4'b0000;
    logic        blank_lz  = 1'b0;
    logic [3:0]  blink_mask = 4'b0000;
    logic [2:0]  brightness = 3'd7;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  en_n;
    logic        frame_done;

    disp7seg_scan_n #(
        .NDIG(NDIG), .PRESCALE(16), .BRIGHT_W(3), .BLINK_FRAMES(2)
    ) dut (
        .clockscan(clockscan), .areset_n(areset_n), .clkenable(clkenable),
        .digits(digits), .dps(dps), .blank_lz(blank_lz),
        .blink_mask(blink_mask), .brightness(brightness),
        .seg_n(seg_n), .dp_n(dp_n), .en_n(en_n), .frame_done(frame_done)
    );

    always #5 clockscan = ~clockscan;

    typedef struct {
        int         tn;
        int         k;
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tnum   = 0;
    int   smp;

    // sample index: number of clock edges since reset release
    always @(posedge clockscan or negedge areset_n) begin
        if (!areset_n) smp <= 0;
        else           smp <= smp + 1;
    end

    exp_t e;
    int   key;
    always @(negedge clockscan) begin
        key = areset_n ? smp : -1;
        if (q.size() != 0) begin
            if (q[0].k == key) begin
                e = q.pop_front();
                checks++;
                if (en_n !== e.en || seg_n !== e.seg ||
                    dp_n !== e.dp || frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL t%0d k=%0d: got en_n=%b seg_n=%b dp_n=%b fd=%b, want en_n=%b seg_n=%b dp_n=%b fd=%b",
                             e.tn, e.k, en_n, seg_n, dp_n, frame_done,
                             e.en, e.seg, e.dp, e.fd);
                end
            end else if (key >= 0 && q[0].k >= 0 && key > q[0].k) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL t%0d k=%0d: sample missed, got sample %0d required %0d",
                         e.tn, e.k, key, e.k);
            end
        end
    end

    task automatic push(input int k, input logic [3:0] en,
                        input logic [6:0] seg, input logic dp,
                        input logic fd);
        exp_t x;
        x.tn = tnum; x.k = k; x.en = en; x.seg = seg; x.dp = dp; x.fd = fd;
        q.push_back(x);
    endtask

    task automatic lit(input int k, input logic [3:0] en,
                       input logic [6:0] seg, input logic dp,
                       input logic fd);
        push(k, en, seg, dp, fd);
    endtask

    task automatic dark(input int k, input logic fd);
        push(k, 4'b1111, 7'h7F, 1'b1, fd);
    endtask

    task automatic do_reset();
        push(-1, 4'b1111, 7'h7F, 1'b1, 1'b0);
        @(posedge clockscan);
        #2 areset_n = 1'b0;
        @(posedge clockscan);
        #2 areset_n = 1'b1;
    endtask

    task automatic wait_smp(input int n);
        int c = 0;
        do begin
            @(negedge clockscan);
            c++;
        end while (smp < n && c < 1000);
        if (smp < n) begin
            checks++;
            errors++;
            $display("FAIL t%0d wait_smp: got sample %0d required %0d", tnum, smp, n);
        end
    endtask

    task automatic wait_empty(input int maxc);
        int c = 0;
        while (q.size() != 0 && c < maxc) begin
            @(negedge clockscan);
            c++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL t%0d timeout: got %0d expectations pending, required 0",
                     tnum, q.size());
            q.delete();
        end
    endtask

    // seg_n patterns (active-low a..g)
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S8 = 7'b0000000;

    initial begin
        // 1: scan order, dead-time, frame pulse
        tnum = 1;
        do_reset();
        dark(0, 0); dark(1, 0);
        lit(2, 4'b0111, S0, 1, 0); lit(16, 4'b0111, S0, 1, 0);
        dark(17, 0);
        lit(18, 4'b1011, S0, 1, 0); lit(32, 4'b1011, S0, 1, 0);
        dark(33, 0);
        lit(34, 4'b1101, S0, 1, 0);
        lit(50, 4'b1110, S0, 1, 0); lit(63, 4'b1110, S0, 1, 0);
        lit(64, 4'b1110, S0, 1, 1);
        dark(65, 0);
        lit(66, 4'b0111, S0, 1, 0);
        lit(128, 4'b1110, S0, 1, 1);
        wait_empty(400);

        // 2: hex decode and decimal point
        tnum = 2;
        digits = 16'h1A2F; dps = 4'b0100;
        do_reset();
        lit(5, 4'b0111, S1, 1, 0);
        lit(21, 4'b1011, SA, 0, 0);
        lit(37, 4'b1101, S2, 1, 0);
        lit(53, 4'b1110, SF, 1, 0);
        wait_empty(200);

        // 3: brightness latch at slot boundary
        tnum = 3;
        digits = 16'h0000; dps = 4'b0000; brightness = 3'd0;
        do_reset();
        lit(2, 4'b0111, S0, 1, 0);
        dark(3, 0); dark(9, 0); dark(16, 0); dark(17, 0);
        lit(18, 4'b1011, S0, 1, 0); lit(24, 4'b1011, S0, 1, 0);
        dark(25, 0);
        lit(34, 4'b1101, S0, 1, 0); lit(40, 4'b1101, S0, 1, 0);
        dark(41, 0);
        wait_smp(8);
        brightness = 3'd3;
        wait_empty(200);

        // 4a: leading-zero blanking
        tnum = 4;
        brightness = 3'd7; blank_lz = 1'b1; digits = 16'h0040;
        do_reset();
        dark(2, 0); dark(16, 0); dark(18, 0); dark(32, 0);
        lit(34, 4'b1101, S4, 1, 0); lit(48, 4'b1101, S4, 1, 0);
        lit(50, 4'b1110, S0, 1, 0);
        wait_empty(200);

        // 4b: all zero leaves only digit 0
        tnum = 5;
        digits = 16'h0000;
        do_reset();
        dark(2, 0); dark(18, 0); dark(34, 0);
        lit(50, 4'b1110, S0, 1, 0); lit(64, 4'b1110, S0, 1, 1);
        dark(66, 0);
        wait_empty(200);

        // 5: blink on digit 0 with two frames per half-period
        tnum = 6;
        blank_lz = 1'b0; blink_mask = 4'b0001;
        do_reset();
        lit(50, 4'b1110, S0, 1, 0); lit(64, 4'b1110, S0, 1, 1);
        lit(114, 4'b1110, S0, 1, 0); lit(128, 4'b1110, S0, 1, 1);
        lit(130, 4'b0111, S0, 1, 0); lit(162, 4'b1101, S0, 1, 0);
        dark(178, 0); dark(192, 1);
        lit(226, 4'b1101, S0, 1, 0);
        dark(242, 0); dark(256, 1);
        lit(306, 4'b1110, S0, 1, 0); lit(320, 4'b1110, S0, 1, 1);
        wait_empty(500);

        // 6: freeze via clkenable, then mid-slot reset pulse
        tnum = 7;
        blink_mask = 4'b0000;
        do_reset();
        lit(8, 4'b0111, S0, 1, 0);
        lit(21, 4'b0111, S8, 1, 0); lit(30, 4'b0111, S8, 1, 0);
        lit(48, 4'b0111, S8, 1, 0); lit(56, 4'b0111, S8, 1, 0);
        dark(57, 0);
        lit(58, 4'b1011, S0, 1, 0); lit(64, 4'b1011, S0, 1, 0);
        lit(104, 4'b1110, S0, 1, 1);
        lit(110, 4'b0111, S8, 1, 0);
        wait_smp(8);
        clkenable = 1'b0;
        wait_smp(20);
        digits = 16'h8000;
        wait_smp(48);
        clkenable = 1'b1;
        wait_smp(110);
        do_reset();
        dark(0, 0); dark(1, 0);
        lit(2, 4'b0111, S8, 1, 0);
        dark(17, 0);
        lit(18, 4'b1011, S0, 1, 0);
        wait_empty(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
